slc3_fetch_unit: RTL and testbench

//  Parametrised instruction-fetch datapath+controller for the SLC-3 core: owns PC, MAR, MDR, IR.

---
 rtl/slc3_pkg.sv | 18 +
 rtl/slc3_ld_reg.sv | 36 +++
 rtl/slc3_fetch_unit.sv | 204 ++++++++++++++++++++
 tb/tb_slc3_fetch_unit.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/slc3_pkg.sv
// Shared types and constants for the SLC-3 fetch path.
//
// Contents:
//   SLC3_WORD_W   : default machine word width (16)
//   fetch_state_t : fetch controller state encoding
package slc3_pkg;

   localparam int SLC3_WORD_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_MAR_LD   = 3'd1,
      ST_MEM_WAIT = 3'd2,
      ST_IR_LD    = 3'd3,
      ST_FAULT    = 3'd4
   } fetch_state_t;

endpackage

// File: rtl/slc3_ld_reg.sv
// Generic register with synchronous active-high reset and load enable.
// Used for the PC, MAR, MDR and IR of the fetch unit.
//
// Parameters:
//   W       : register width
//   RST_VAL : value taken on reset
// Ports:
//   i_clk   : clock, rising edge
//   i_reset : synchronous active-high reset
//   i_ld    : load enable; register holds when low
//   i_d     : load data
//   o_q     : register contents
module slc3_ld_reg #(
   parameter int           W       = 16,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_ld,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_q;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_q <= RST_VAL;
      end else if (i_ld) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/slc3_fetch_unit.sv
// SLC-3 instruction fetch unit: owns PC, MAR, MDR and IR and sequences
// PC->MAR, memory read with ready handshake, MDR->IR and PC increment.
// Supports an external PC redirect on any cycle.
//
// Optional feature (macro SLC3_FETCH_TIMEOUT_EN): bounds the memory wait to
// TIMEOUT_CYC cycles; on expiry the unit parks in FAULT with a sticky
// o_fetch_fault until reset. Without the macro the wait is unbounded and
// o_fetch_fault is tied low.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | waiting for i_fetch_req; o_fetch_done pulses here
//   MAR_LD   | MAR <= PC, PC <= PC+1 (unless redirected)
//   MEM_WAIT | o_mem_rd_en high until i_mem_ready; MDR <= i_mem_rdata
//   IR_LD    | IR <= MDR, schedule o_fetch_done
//   FAULT    | memory timed out; everything frozen until reset (macro only)
//
// Ports:
//   i_clk, i_reset      : clock, synchronous active-high reset
//   i_fetch_req         : start a fetch (sampled only in IDLE)
//   i_pc_ld/i_pc_ld_val : PC redirect
//   i_mem_rdata/ready   : memory read data and completion
//   o_mem_rd_en/addr    : memory read request and address (= MAR)
//   o_pc_out, o_mdr_out, o_ir_out : architectural registers
//   o_fetch_busy        : high whenever not IDLE
//   o_fetch_done        : registered 1-cycle pulse, new IR visible same cycle
//   o_fetch_fault       : sticky timeout flag
module slc3_fetch_unit
   import slc3_pkg::*;
#(
   parameter int                DATA_W      = SLC3_WORD_W,
   parameter int                ADDR_W      = 16,
   parameter logic [ADDR_W-1:0] RESET_PC    = '0,
   parameter int                TIMEOUT_CYC = 15
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_fetch_req,
   input  logic              i_pc_ld,
   input  logic [ADDR_W-1:0] i_pc_ld_val,
   input  logic [DATA_W-1:0] i_mem_rdata,
   input  logic              i_mem_ready,
   output logic              o_mem_rd_en,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [ADDR_W-1:0] o_pc_out,
   output logic [DATA_W-1:0] o_mdr_out,
   output logic [DATA_W-1:0] o_ir_out,
   output logic              o_fetch_busy,
   output logic              o_fetch_done,
   output logic              o_fetch_fault
);

   fetch_state_t      r_state;
   fetch_state_t      w_state_nxt;
   logic              r_fetch_done;

   logic [ADDR_W-1:0] w_pc;
   logic [ADDR_W-1:0] w_mar;
   logic [DATA_W-1:0] w_mdr;
   logic [DATA_W-1:0] w_ir;

   logic              w_pc_ld;
   logic [ADDR_W-1:0] w_pc_nxt;
   logic              w_mar_ld;
   logic              w_mdr_ld;
   logic              w_ir_ld;
   logic              w_mem_rd_en;

`ifdef SLC3_FETCH_TIMEOUT_EN
   localparam int                CNT_W    = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
   // Value held during the last allowed wait cycle; a miss there trips FAULT.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] r_wait_cnt;
   logic             r_fetch_fault;

   // Cleared outside MEM_WAIT so every wait period starts from zero.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_wait_cnt <= '0;
      end else if (r_state != ST_MEM_WAIT) begin
         r_wait_cnt <= '0;
      end else if (!i_mem_ready && (r_wait_cnt != CNT_LAST)) begin
         r_wait_cnt <= r_wait_cnt + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_fetch_fault <= 1'b0;
      end else if (w_state_nxt == ST_FAULT) begin
         r_fetch_fault <= 1'b1;
      end
   end

   assign o_fetch_fault = r_fetch_fault;
`else
   assign o_fetch_fault = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= ST_IDLE;
         r_fetch_done <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_fetch_done <= (r_state == ST_IR_LD);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_mar_ld    = 1'b0;
      w_mdr_ld    = 1'b0;
      w_ir_ld     = 1'b0;
      w_mem_rd_en = 1'b0;
      w_pc_ld     = 1'b0;
      w_pc_nxt    = w_pc;

      case (r_state)
         ST_IDLE: begin
            if (i_fetch_req) begin
               w_state_nxt = ST_MAR_LD;
            end
         end
         ST_MAR_LD: begin
            w_mar_ld    = 1'b1;
            w_pc_ld     = 1'b1;
            w_pc_nxt    = w_pc + 1'b1;
            w_state_nxt = ST_MEM_WAIT;
         end
         ST_MEM_WAIT: begin
            w_mem_rd_en = 1'b1;
            if (i_mem_ready) begin
               w_mdr_ld    = 1'b1;
               w_state_nxt = ST_IR_LD;
            end
`ifdef SLC3_FETCH_TIMEOUT_EN
            else if (r_wait_cnt == CNT_LAST) begin
               w_state_nxt = ST_FAULT;
            end
`endif
         end
         ST_IR_LD: begin
            w_ir_ld     = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: begin
`ifdef SLC3_FETCH_TIMEOUT_EN
            w_state_nxt = ST_FAULT;
`else
            w_state_nxt = ST_IDLE;
`endif
         end
      endcase

      // Redirect overrides the MAR_LD increment; MAR still captures the old PC.
      if (i_pc_ld && (r_state != ST_FAULT)) begin
         w_pc_ld  = 1'b1;
         w_pc_nxt = i_pc_ld_val;
      end
   end

   slc3_ld_reg #(.W(ADDR_W), .RST_VAL(RESET_PC)) u_pc (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_ld    (w_pc_ld),
      .i_d     (w_pc_nxt),
      .o_q     (w_pc)
   );

   slc3_ld_reg #(.W(ADDR_W), .RST_VAL('0)) u_mar (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_ld    (w_mar_ld),
      .i_d     (w_pc),
      .o_q     (w_mar)
   );

   slc3_ld_reg #(.W(DATA_W), .RST_VAL('0)) u_mdr (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_ld    (w_mdr_ld),
      .i_d     (i_mem_rdata),
      .o_q     (w_mdr)
   );

   slc3_ld_reg #(.W(DATA_W), .RST_VAL('0)) u_ir (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_ld    (w_ir_ld),
      .i_d     (w_mdr),
      .o_q     (w_ir)
   );

   assign o_mem_rd_en  = w_mem_rd_en;
   assign o_mem_addr   = w_mar;
   assign o_pc_out     = w_pc;
   assign o_mdr_out    = w_mdr;
   assign o_ir_out     = w_ir;
   assign o_fetch_busy = (r_state != ST_IDLE);
   assign o_fetch_done = r_fetch_done;

endmodule

// File: tb/tb_slc3_fetch_unit.sv
// Self-checking bench for slc3_fetch_unit (RESET_PC='h3000, TIMEOUT_CYC=3).
module tb_slc3_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        fetch_req;
   logic        pc_ld;
   logic [15:0] pc_ld_val;
   logic [15:0] mem_rdata;
   logic        mem_ready;
   logic        mem_rd_en;
   logic [15:0] mem_addr;
   logic [15:0] pc_out;
   logic [15:0] mdr_out;
   logic [15:0] ir_out;
   logic        fetch_busy;
   logic        fetch_done;
   logic        fetch_fault;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   slc3_fetch_unit #(
      .DATA_W      (16),
      .ADDR_W      (16),
      .RESET_PC    (16'h3000),
      .TIMEOUT_CYC (3)
   ) dut (
      .i_clk         (clk),
      .i_reset       (reset),
      .i_fetch_req   (fetch_req),
      .i_pc_ld       (pc_ld),
      .i_pc_ld_val   (pc_ld_val),
      .i_mem_rdata   (mem_rdata),
      .i_mem_ready   (mem_ready),
      .o_mem_rd_en   (mem_rd_en),
      .o_mem_addr    (mem_addr),
      .o_pc_out      (pc_out),
      .o_mdr_out     (mdr_out),
      .o_ir_out      (ir_out),
      .o_fetch_busy  (fetch_busy),
      .o_fetch_done  (fetch_done),
      .o_fetch_fault (fetch_fault)
   );

   typedef struct {
      int          dly;
      logic [15:0] data;
      logic [15:0] exp_addr;
      int          exp_rd;
      int          exp_done;
      logic [15:0] exp_pc;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Advance one clock; inputs/outputs are then observed 1ns after the edge.
   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      reset = 1'b1; fetch_req = 1'b0; pc_ld = 1'b0; pc_ld_val = '0;
      mem_ready = 1'b0; mem_rdata = 16'hBAD0;
      step; step;
      reset = 1'b0;
   endtask

   // One fetch from IDLE; ready is given on the (dly+1)-th MEM_WAIT cycle.
   // Cycle 0 is the cycle fetch_req is presented.
   task automatic run_fetch(input int dly, input logic [15:0] data,
                            output logic [15:0] addr, output int rd_cyc,
                            output int done_cyc, output int done_cnt,
                            output logic [15:0] ir_at_done);
      int w;
      w = 0; rd_cyc = 0; done_cyc = -1; done_cnt = 0; addr = 16'hxxxx; ir_at_done = 16'hxxxx;
      fetch_req = 1'b1;
      for (int c = 0; c < 60; c++) begin
         if (mem_rd_en) begin
            addr = mem_addr;
            rd_cyc++;
            if (w == dly) begin
               mem_ready = 1'b1;
               mem_rdata = data;
            end
            w++;
         end
         if (fetch_done) begin
            done_cnt++;
            if (done_cyc < 0) begin
               done_cyc   = c;
               ir_at_done = ir_out;
            end
         end
         step;
         fetch_req = 1'b0; mem_ready = 1'b0; mem_rdata = 16'hBAD0;
         if (done_cyc >= 0 && c > done_cyc + 2) break;
      end
   endtask

   vec_t        vecs[4];
   logic [15:0] a;
   logic [15:0] ird;
   int          rd, dn, dc;
   logic [15:0] addrs[$];
   int          dones[$];

   initial begin
      vecs[0] = '{0, 16'h1234, 16'h3000, 1, 4, 16'h3001};
      vecs[1] = '{5, 16'hABCD, 16'h3001, 6, 9, 16'h3002};
      vecs[2] = '{1, 16'h0000, 16'h3002, 2, 5, 16'h3003};
      vecs[3] = '{2, 16'hFFFF, 16'h3003, 3, 6, 16'h3004};

      do_reset;
      check("rst_pc",    32'(pc_out),     32'h3000);
      check("rst_ir",    32'(ir_out),     32'h0);
      check("rst_mdr",   32'(mdr_out),    32'h0);
      check("rst_addr",  32'(mem_addr),   32'h0);
      check("rst_busy",  32'(fetch_busy), 32'h0);
      check("rst_done",  32'(fetch_done), 32'h0);
      check("rst_rd_en", 32'(mem_rd_en),  32'h0);
      check("rst_fault", 32'(fetch_fault), 32'h0);

      for (int i = 0; i < 4; i++) begin
         run_fetch(vecs[i].dly, vecs[i].data, a, rd, dc, dn, ird);
         check($sformatf("v%0d_addr", i),     32'(a),   32'(vecs[i].exp_addr));
         check($sformatf("v%0d_rd_cyc", i),   32'(rd),  32'(vecs[i].exp_rd));
         check($sformatf("v%0d_done_cyc", i), 32'(dc),  32'(vecs[i].exp_done));
         check($sformatf("v%0d_done_cnt", i), 32'(dn),  32'd1);
         check($sformatf("v%0d_ir", i),       32'(ird), 32'(vecs[i].data));
         check($sformatf("v%0d_pc", i),       32'(pc_out), 32'(vecs[i].exp_pc));
      end

      // PC wrap: redirect to FFFF while idle, then fetch.
      pc_ld = 1'b1; pc_ld_val = 16'hFFFF;
      step;
      pc_ld = 1'b0;
      check("redir_idle_pc", 32'(pc_out), 32'hFFFF);
      run_fetch(0, 16'h5555, a, rd, dc, dn, ird);
      check("wrap_addr", 32'(a),      32'hFFFF);
      check("wrap_pc",   32'(pc_out), 32'h0000);
      check("wrap_ir",   32'(ird),    32'h5555);

      // Redirect in MAR_LD beats increment; MAR keeps old PC; fetch completes.
      fetch_req = 1'b1;
      step;                                // cycle 1: MAR_LD
      fetch_req = 1'b0;
      pc_ld = 1'b1; pc_ld_val = 16'h4000;
      check("marld_busy", 32'(fetch_busy), 32'h1);
      step;                                // cycle 2: MEM_WAIT
      pc_ld = 1'b0;
      check("marld_addr",  32'(mem_addr),  32'h0000);
      check("marld_pc",    32'(pc_out),    32'h4000);
      check("marld_rd_en", 32'(mem_rd_en), 32'h1);
      pc_ld = 1'b1; pc_ld_val = 16'h5000;  // redirect during wait does not cancel
      fetch_req = 1'b1;                    // ignored outside IDLE
      mem_ready = 1'b1; mem_rdata = 16'h7777;
      step;                                // cycle 3: IR_LD
      pc_ld = 1'b0; fetch_req = 1'b0; mem_ready = 1'b0; mem_rdata = 16'hBAD0;
      check("wait_redir_pc", 32'(pc_out), 32'h5000);
      check("mdr_loaded",    32'(mdr_out), 32'h7777);
      step;                                // cycle 4: IDLE, done
      check("marld_done", 32'(fetch_done), 32'h1);
      check("marld_ir",   32'(ir_out),     32'h7777);
      check("marld_idle", 32'(fetch_busy), 32'h0);
      step;
      check("marld_done_1pulse", 32'(fetch_done), 32'h0);
      check("no_queued_req",     32'(fetch_busy), 32'h0);

      // Back-to-back with fetch_req held high and immediate ready.
      do_reset;
      fetch_req = 1'b1;
      for (int c = 0; c < 13; c++) begin
         if (mem_rd_en) begin
            addrs.push_back(mem_addr);
            mem_ready = 1'b1; mem_rdata = 16'(16'h0100 + c);
         end
         if (fetch_done) dones.push_back(c);
         step;
         mem_ready = 1'b0;
      end
      fetch_req = 1'b0;
      check("b2b_nrd",   32'(addrs.size()), 32'd3);
      check("b2b_ndone", 32'(dones.size()), 32'd3);
      if (addrs.size() == 3) begin
         check("b2b_a0", 32'(addrs[0]), 32'h3000);
         check("b2b_a1", 32'(addrs[1]), 32'h3001);
         check("b2b_a2", 32'(addrs[2]), 32'h3002);
      end
      if (dones.size() == 3) begin
         check("b2b_d0", 32'(dones[0]), 32'd4);
         check("b2b_d1", 32'(dones[1]), 32'd8);
         check("b2b_d2", 32'(dones[2]), 32'd12);
      end

`ifdef SLC3_FETCH_TIMEOUT_EN
      // Ready on the last allowed wait cycle completes normally.
      do_reset;
      run_fetch(2, 16'h2468, a, rd, dc, dn, ird);
      check("to_edge_rd",    32'(rd),          32'd3);
      check("to_edge_done",  32'(dc),          32'd6);
      check("to_edge_fault", 32'(fetch_fault), 32'h0);
      check("to_edge_ir",    32'(ird),         32'h2468);

      // No ready: FAULT after 3 wait cycles, then frozen until reset.
      do_reset;
      fetch_req = 1'b1;
      step; fetch_req = 1'b0;              // MAR_LD
      rd = 0;
      for (int c = 0; c < 6; c++) begin
         step;
         if (mem_rd_en) rd++;
      end
      check("to_rd_cyc", 32'(rd),          32'd3);
      check("to_fault",  32'(fetch_fault), 32'h1);
      check("to_busy",   32'(fetch_busy),  32'h1);
      check("to_rd_en",  32'(mem_rd_en),   32'h0);
      pc_ld = 1'b1; pc_ld_val = 16'h1111; mem_ready = 1'b1; mem_rdata = 16'h9999;
      step; step;
      pc_ld = 1'b0; mem_ready = 1'b0;
      check("to_pc_frozen",  32'(pc_out),      32'h3001);
      check("to_mdr_frozen", 32'(mdr_out),     32'h0);
      check("to_sticky",     32'(fetch_fault), 32'h1);
      do_reset;
      check("to_rst_fault", 32'(fetch_fault), 32'h0);
      check("to_rst_busy",  32'(fetch_busy),  32'h0);
`else
      // Without timeout: MEM_WAIT holds indefinitely, then completes.
      do_reset;
      fetch_req = 1'b1;
      step; fetch_req = 1'b0;
      for (int c = 0; c < 20; c++) step;
      check("nto_rd_en", 32'(mem_rd_en),   32'h1);
      check("nto_busy",  32'(fetch_busy),  32'h1);
      check("nto_fault", 32'(fetch_fault), 32'h0);
      mem_ready = 1'b1; mem_rdata = 16'h2222;
      step;
      mem_ready = 1'b0;
      step;
      check("nto_done", 32'(fetch_done), 32'h1);
      check("nto_ir",   32'(ir_out),     32'h2222);
`endif

      // Reset mid-fetch wins.
      fetch_req = 1'b1;
      step; step;
      fetch_req = 1'b0;
      reset = 1'b1;
      step;
      reset = 1'b0;
      check("midrst_busy",  32'(fetch_busy), 32'h0);
      check("midrst_rd_en", 32'(mem_rd_en),  32'h0);
      check("midrst_pc",    32'(pc_out),     32'h3000);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
